clock_gen_prog: RTL and testbench

- Parametrised successor to the fixed-ratio clock generator: NUM_CH independent divider channels, each with a runtime-programmable integer ratio.
- Per channel: divided clock output, rising-edge strobe and transition counter.
- Ratio changes take effect only at a period boundary, so no runt pulses occur.
- Sits beside the board clock; feeds slow logic and LED/debug timing.

---
 rtl/clock_gen_prog_if.sv | 27 ++
 rtl/clock_gen_prog.sv | 142 ++++++++++++++
 tb/tb_clock_gen_prog.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/clock_gen_prog_if.sv
// rtl/clock_gen_prog_if.sv - control and divided-clock bundle for clock_gen_prog
//   en/load/div_val             : per-channel enable, ratio load strobe, ratio fields (master drives)
//   clk_out/clk_strobe          : divided clocks and their rising-edge strobes (slave drives)
//   div_active/toggle_counter   : ratio in use and clk_out transition count per channel (slave drives)
interface clock_gen_prog_if #(
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 8,
  parameter int TOGGLE_W = 8
);
  logic [NUM_CH-1:0]          en;
  logic [NUM_CH-1:0]          load;
  logic [NUM_CH*DIV_W-1:0]    div_val;
  logic [NUM_CH-1:0]          clk_out;
  logic [NUM_CH-1:0]          clk_strobe;
  logic [NUM_CH*DIV_W-1:0]    div_active;
  logic [NUM_CH*TOGGLE_W-1:0] toggle_counter;

  modport master (
    output en, load, div_val,
    input  clk_out, clk_strobe, div_active, toggle_counter
  );

  modport slave (
    input  en, load, div_val,
    output clk_out, clk_strobe, div_active, toggle_counter
  );
endinterface

// File: rtl/clock_gen_prog.sv
// rtl/clock_gen_prog.sv - NUM_CH independent runtime-programmable integer clock dividers
//   clk_in : system clock, all state on its rising edge
//   rst    : synchronous active-low reset
//   bus    : clock_gen_prog_if.slave (en, load, div_val in; clk_out, clk_strobe,
//            div_active, toggle_counter out)
//   CLOCK_GEN_DUTY50_EN : when defined, odd ratios get a falling-edge extension
//                         flop so clk_out is high for exactly N/2 cycles
module clock_gen_prog #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int TOGGLE_W    = 8,
  parameter int DEFAULT_DIV = 2
) (
  input logic              clk_in,
  input logic              rst,
  clock_gen_prog_if.slave  bus
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0]    cnt_q   [NUM_CH];
  logic [DIV_W-1:0]    cnt_d   [NUM_CH];
  logic [DIV_W-1:0]    div_q   [NUM_CH];
  logic [DIV_W-1:0]    div_d   [NUM_CH];
  logic [DIV_W-1:0]    pend_q  [NUM_CH];
  logic [DIV_W-1:0]    pend_d  [NUM_CH];
  logic [TOGGLE_W-1:0] tog_q   [NUM_CH];
  logic [TOGGLE_W-1:0] tog_d   [NUM_CH];
  logic [NUM_CH-1:0]   pend_flag_q, pend_flag_d;
  logic [NUM_CH-1:0]   clk_q, clk_d;
  logic [NUM_CH-1:0]   strobe_q, strobe_d;
  logic [DIV_W-1:0]    slice;

  // Ratios below 2 cannot produce a clock, so they are forced to 2.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
    return (v < DIV_W'(2)) ? DIV_W'(2) : v;
  endfunction

  always_comb begin
    slice       = '0;
    pend_flag_d = pend_flag_q;
    clk_d       = clk_q;
    strobe_d    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]  = cnt_q[i];
      div_d[i]  = div_q[i];
      pend_d[i] = pend_q[i];
      tog_d[i]  = tog_q[i];
      slice     = bus.div_val[i*DIV_W +: DIV_W];
      if (!bus.en[i]) begin
        // Idle channel: nothing to protect, so ratio updates land at once.
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
        if (pend_flag_q[i]) begin
          div_d[i]       = clamp_div(pend_q[i]);
          pend_flag_d[i] = 1'b0;
        end
        if (bus.load[i]) begin
          div_d[i]       = clamp_div(slice);
          pend_flag_d[i] = 1'b0;
        end
      end else begin
        if (cnt_q[i] == div_q[i] - 1'b1) begin
          // Period boundary: the only place a new ratio may take over.
          cnt_d[i]    = '0;
          clk_d[i]    = 1'b1;
          strobe_d[i] = 1'b1;
          if (pend_flag_q[i]) begin
            div_d[i]       = clamp_div(pend_q[i]);
            pend_flag_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
          if (cnt_q[i] + 1'b1 == (div_q[i] >> 1)) begin
            clk_d[i] = 1'b0;
          end
        end
        // A load coinciding with a wrap is held for the following wrap.
        if (bus.load[i]) begin
          pend_d[i]      = slice;
          pend_flag_d[i] = 1'b1;
        end
      end
      if (clk_d[i] != clk_q[i]) begin
        tog_d[i] = tog_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      pend_flag_q <= '0;
      clk_q       <= '0;
      strobe_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= '0;
        div_q[i]  <= RST_DIV;
        pend_q[i] <= '0;
        tog_q[i]  <= '0;
      end
    end else begin
      pend_flag_q <= pend_flag_d;
      clk_q       <= clk_d;
      strobe_q    <= strobe_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        div_q[i]  <= div_d[i];
        pend_q[i] <= pend_d[i];
        tog_q[i]  <= tog_d[i];
      end
    end
  end

`ifdef CLOCK_GEN_DUTY50_EN
  logic [NUM_CH-1:0] neg_q, neg_d;

  always_comb begin
    neg_d = clk_q;
  end

  // Half-cycle delayed copy stretches the high phase of odd ratios by 0.5 cycle.
  always_ff @(negedge clk_in) begin
    if (!rst) begin
      neg_q <= '0;
    end else begin
      neg_q <= neg_d;
    end
  end
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
`ifdef CLOCK_GEN_DUTY50_EN
    assign bus.clk_out[g] = clk_q[g] | (neg_q[g] & div_q[g][0]);
`else
    assign bus.clk_out[g] = clk_q[g];
`endif
    assign bus.clk_strobe[g]                        = strobe_q[g];
    assign bus.div_active[g*DIV_W +: DIV_W]         = div_q[g];
    assign bus.toggle_counter[g*TOGGLE_W +: TOGGLE_W] = tog_q[g];
  end

endmodule

// File: tb/tb_clock_gen_prog.sv
// tb/tb_clock_gen_prog.sv - scoreboard bench for clock_gen_prog
module tb_clock_gen_prog;
  localparam int NUM_CH   = 4;
  localparam int DIV_W    = 8;
  localparam int TOGGLE_W = 8;
`ifdef CLOCK_GEN_DUTY50_EN
  localparam bit DUTY50 = 1'b1;
`else
  localparam bit DUTY50 = 1'b0;
`endif

  typedef struct {
    int period;
    int high;
    int div;
    int tog;
  } exp_t;

  exp_t exp_q [NUM_CH][$];

  logic clk_in = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   ph_e  = 0;

  clock_gen_prog_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .TOGGLE_W(TOGGLE_W)) tif ();

  clock_gen_prog #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .TOGGLE_W(TOGGLE_W), .DEFAULT_DIV(2)
  ) dut (
    .clk_in(clk_in),
    .rst   (rst),
    .bus   (tif)
  );

  always #5 clk_in = ~clk_in;

  // High time in half cycles of one period of ratio n.
  function automatic int hh(input int n);
    return ((n % 2) == 0 || DUTY50) ? n : n - 1;
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int ch, input int p, input int h, input int d, input int t);
    exp_t e;
    e.period = p; e.high = h; e.div = d; e.tog = t;
    exp_q[ch].push_back(e);
  endtask

  task automatic run_to(input int e);
    while (ph_e < e) begin
      @(negedge clk_in);
      #1;
      ph_e++;
    end
  endtask

  task automatic new_phase(input logic [NUM_CH-1:0] en_v);
    tif.en = en_v;
    ph_e   = 0;
  endtask

  task automatic do_load(input int ch, input int v, input int e);
    run_to(e - 1);
    tif.load[ch] = 1'b1;
    tif.div_val[ch*DIV_W +: DIV_W] = DIV_W'(v);
    run_to(e);
    tif.load = '0;
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < NUM_CH; i++) begin
      check($sformatf("%s_clk_out%0d", tag, i), int'(tif.clk_out[i]), 0);
      check($sformatf("%s_strobe%0d", tag, i), int'(tif.clk_strobe[i]), 0);
      check($sformatf("%s_toggle%0d", tag, i), int'(tif.toggle_counter[i*TOGGLE_W +: TOGGLE_W]), 0);
      check($sformatf("%s_div%0d", tag, i), int'(tif.div_active[i*DIV_W +: DIV_W]), 2);
    end
  endtask

  // Monitor: counts enabled edges and high half-cycles per channel, and
  // compares against the scoreboard on every strobe.
  initial begin
    int cyc_cnt [NUM_CH];
    int hi_cnt  [NUM_CH];
    logic [NUM_CH-1:0] en_s;
    logic rst_s;
    exp_t e;
    for (int i = 0; i < NUM_CH; i++) begin
      cyc_cnt[i] = 0;
      hi_cnt[i]  = 0;
    end
    forever begin
      @(posedge clk_in);
      en_s  = tif.en;
      rst_s = rst;
      #2;
      for (int i = 0; i < NUM_CH; i++) begin
        if (rst_s !== 1'b1 || en_s[i] !== 1'b1) begin
          cyc_cnt[i] = 0;
          hi_cnt[i]  = 0;
        end else begin
          cyc_cnt[i]++;
          if (tif.clk_strobe[i] === 1'b1) begin
            if (exp_q[i].size() == 0) begin
              check($sformatf("unexpected_strobe_ch%0d", i), 1, 0);
            end else begin
              e = exp_q[i].pop_front();
              check($sformatf("period_ch%0d", i), cyc_cnt[i], e.period);
              check($sformatf("high_halves_ch%0d", i), hi_cnt[i], e.high);
              check($sformatf("div_active_ch%0d", i), int'(tif.div_active[i*DIV_W +: DIV_W]), e.div);
              if (e.tog >= 0) begin
                check($sformatf("toggle_ch%0d", i), int'(tif.toggle_counter[i*TOGGLE_W +: TOGGLE_W]), e.tog);
              end
            end
            cyc_cnt[i] = 0;
            hi_cnt[i]  = 0;
          end
          if (tif.clk_out[i] === 1'b1) hi_cnt[i]++;
        end
      end
      @(negedge clk_in);
      #2;
      for (int i = 0; i < NUM_CH; i++) begin
        if (tif.clk_out[i] === 1'b1) hi_cnt[i]++;
      end
    end
  end

  initial begin
    rst         = 1'b0;
    tif.en      = '0;
    tif.load    = '0;
    tif.div_val = '0;

    // Reset held for 100 ns.
    run_to(10);
    check_reset_state("reset");

    // Defaults on all channels: ratio 2, toggle counter wraps past 255.
    rst = 1'b1;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int k = 1; k <= 150; k++) begin
        push_exp(ch, 2, (k == 1) ? 0 : hh(2), 2, (2 * k - 1) % 256);
      end
    end
    new_phase('1);
    run_to(300);
    for (int i = 0; i < NUM_CH; i++) begin
      check($sformatf("toggle_after300_ch%0d", i), int'(tif.toggle_counter[i*TOGGLE_W +: TOGGLE_W]), 43);
    end
    new_phase('0);
    run_to(2);

    // Channel 1 ratio 5.
    push_exp(1, 2, 0, 5, -1);
    for (int k = 0; k < 4; k++) push_exp(1, 5, hh(5), 5, -1);
    new_phase(4'b0010);
    do_load(1, 5, 1);
    run_to(24);
    new_phase('0);
    run_to(2);

    // Channel 0: mid-period change, load on wrap, repeated loads, clamping.
    push_exp(0, 2, 0,      4, -1);
    push_exp(0, 4, hh(4),  4, -1);
    push_exp(0, 4, hh(4),  6, -1);
    push_exp(0, 6, hh(6),  6, -1);
    push_exp(0, 6, hh(6),  6, -1);
    push_exp(0, 6, hh(6),  3, -1);
    push_exp(0, 3, hh(3),  3, -1);
    push_exp(0, 3, hh(3),  7, -1);
    push_exp(0, 7, hh(7),  7, -1);
    push_exp(0, 7, hh(7),  2, -1);
    push_exp(0, 2, hh(2),  2, -1);
    push_exp(0, 2, hh(2),  5, -1);
    push_exp(0, 5, hh(5),  2, -1);
    push_exp(0, 2, hh(2),  2, -1);
    push_exp(0, 2, hh(2),  2, -1);
    new_phase(4'b0001);
    do_load(0, 4, 1);
    do_load(0, 6, 8);
    run_to(9);
    check("div_held_until_wrap", int'(tif.div_active[0 +: DIV_W]), 4);
    do_load(0, 3, 22);
    do_load(0, 9, 32);
    do_load(0, 7, 33);
    do_load(0, 1, 42);
    do_load(0, 5, 51);
    do_load(0, 0, 53);
    run_to(62);
    new_phase('0);
    run_to(2);

    // Reset during the high phase of channel 1, then restart from defaults.
    push_exp(1, 5, 0, 5, -1);
    new_phase(4'b0010);
    run_to(5);
    rst = 1'b0;
    run_to(6);
    check_reset_state("midreset");
    rst = 1'b1;
    push_exp(1, 2, 0,     2, 1);
    push_exp(1, 2, hh(2), 2, 3);
    push_exp(1, 2, hh(2), 2, 5);
    run_to(12);
    new_phase('0);
    run_to(4);

    for (int i = 0; i < NUM_CH; i++) begin
      check($sformatf("missing_strobes_ch%0d", i), exp_q[i].size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
